sram_fifo_ctrl: RTL

Synchronous FIFO controller built around one external single-port 128x24 SRAM macro (sram6t128x24). It drives the macro's address, chip-select, write-enable, byte-mask and data-in pins, and consumes its registered 1-cycle-latency read data. It exposes valid/ready enqueue and dequeue ports. A small register output buffer hides SRAM read latency and gives deq_bits straight from a flop.

---
 rtl/sram_fifo_ctrl_pkg.sv | 11 +
 rtl/sram_fifo_ctrl_obuf.sv | 43 ++++
 rtl/sram_fifo_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared sizing for the SRAM-backed FIFO controller and its output buffer.
package sram_fifo_pkg;
  localparam int DEPTH      = 128;
  localparam int AW         = $clog2(DEPTH);
  localparam int DW         = 24;
  localparam int NBM        = DW / 8;
  localparam int OBUF_DEPTH = 3;
  localparam int CW         = 8;
  localparam int OB_CW      = $clog2(OBUF_DEPTH + 1);
  localparam logic [NBM-1:0] WBM_ALL = '1;
endpackage

// File: rtl/sram_fifo_ctrl_obuf.sv
// Small register FIFO in front of the consumer; entry 0 is always the head,
// so the head data leaves straight from a flop.
module sram_fifo_obuf
  import sram_fifo_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DW-1:0]    din,
  input  logic             pop,
  output logic [DW-1:0]    head,
  output logic [OB_CW-1:0] cnt
);
  logic [DW-1:0]    ent     [OBUF_DEPTH];
  logic [DW-1:0]    ent_nxt [OBUF_DEPTH];
  logic [OB_CW-1:0] wr_idx;

  // Pop shifts towards the head; a simultaneous push lands one slot lower.
  always_comb begin
    ent_nxt = ent;
    wr_idx  = pop ? (cnt - OB_CW'(1)) : cnt;
    if (pop) begin
      for (int i = 0; i < OBUF_DEPTH - 1; i++) ent_nxt[i] = ent[i+1];
    end
    if (push) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        if (OB_CW'(i) == wr_idx) ent_nxt[i] = din;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      ent <= '{default: '0};
    end else begin
      cnt <= cnt + OB_CW'(push) - OB_CW'(pop);
      ent <= ent_nxt;
    end
  end

  assign head = ent[0];
endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over one single-port 128x24 SRAM with a 3-entry output buffer.
// Define SRAM_FIFO_BYPASS_EN to let enqueues skip the SRAM when it is empty.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           enq_valid,
  output logic           enq_ready,
  input  logic [DW-1:0]  enq_bits,
  output logic           deq_valid,
  input  logic           deq_ready,
  output logic [DW-1:0]  deq_bits,
  output logic [CW-1:0]  count,
  output logic [AW-1:0]  sram_a,
  output logic           sram_csb,
  output logic           sram_web,
  output logic [NBM-1:0] sram_wbm,
  output logic           sram_oeb,
  output logic [DW-1:0]  sram_i,
  input  logic [DW-1:0]  sram_o
);
  // Handshakes: a word moves on a port only in a cycle where valid && ready;
  // valid never depends on ready, and ready is computed from registered state.
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [OB_CW:0] OBUF_C  = (OB_CW + 1)'(OBUF_DEPTH);

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    sram_cnt;
  logic             rd_inflight;
  logic [OB_CW-1:0] ob_cnt;
  logic             rd_sel, enq_fire, wr_fire, byp, byp_fire;
  logic             ob_push, ob_pop;
  logic [DW-1:0]    ob_din;

  // Read only when the buffer is guaranteed room at capture time.
  assign rd_sel = (sram_cnt != '0) &&
                  (({1'b0, ob_cnt} + {{OB_CW{1'b0}}, rd_inflight}) < OBUF_C);

`ifdef SRAM_FIFO_BYPASS_EN
  assign byp = (sram_cnt == '0) && !rd_inflight && (ob_cnt < OB_CW'(OBUF_DEPTH));
`else
  assign byp = 1'b0;
`endif

  assign enq_ready = (sram_cnt < DEPTH_C) && !rd_sel;
  assign enq_fire  = enq_valid && enq_ready;
  assign wr_fire   = enq_fire && !byp;
  assign byp_fire  = enq_fire && byp;

  assign sram_a   = rd_sel ? rd_ptr : wr_ptr;
  assign sram_csb = !(rd_sel || wr_fire);
  assign sram_web = !wr_fire;
  assign sram_wbm = WBM_ALL;
  assign sram_oeb = 1'b0;
  assign sram_i   = enq_bits;

  // Bypass needs no read in flight, so capture and bypass never collide.
  assign ob_push   = rd_inflight || byp_fire;
  assign ob_din    = rd_inflight ? sram_o : enq_bits;
  assign deq_valid = (ob_cnt != '0);
  assign ob_pop    = deq_valid && deq_ready;
  assign count     = sram_cnt + CW'(rd_inflight) + CW'(ob_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sram_cnt    <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (rd_sel)  rd_ptr <= rd_ptr + AW'(1);
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      sram_cnt    <= sram_cnt + CW'(wr_fire) - CW'(rd_sel);
      rd_inflight <= rd_sel;
    end
  end

  sram_fifo_obuf u_obuf (
    .clk   (clk),
    .reset (reset),
    .push  (ob_push),
    .din   (ob_din),
    .pop   (ob_pop),
    .head  (deq_bits),
    .cnt   (ob_cnt)
  );
endmodule
